// File: rtl/prime_number.sv
// Sequential prime scanner: trial-divides every candidate from 2 up to numMax,
// one divisor per clock, and reports the latest prime, last checked value and prime count.
module prime_number #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] numMax,
    output logic [W-1:0] prime,
    output logic [W-1:0] numberChecked,
    output logic [W-1:0] numberOfPrimes
);

    typedef enum logic [1:0] {
        START,
        TEST,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]   max_q, max_d;
    logic [W-1:0]   cand_q, cand_d;
    logic [W-1:0]   div_q, div_d;
    logic [W-1:0]   prime_q, prime_d;
    logic [W-1:0]   checked_q, checked_d;
    logic [W-1:0]   count_q, count_d;

    logic [2*W-1:0] div_sq;
    logic [W-1:0]   rem;
    logic           is_prime;
    logic           is_composite;
    logic           limit_changed;

    // Square is kept at full double width so the prime test never truncates.
    always_comb begin
        div_sq        = {{W{1'b0}}, div_q} * {{W{1'b0}}, div_q};
        rem           = cand_q % div_q;
        is_prime      = div_sq > {{W{1'b0}}, cand_q};
        is_composite  = (rem == '0);
        limit_changed = (numMax != max_q);
    end

    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        cand_d    = cand_q;
        div_d     = div_q;
        prime_d   = prime_q;
        checked_d = checked_q;
        count_d   = count_q;

        case (state_q)
            START: begin
                max_d     = numMax;
                prime_d   = '0;
                checked_d = '0;
                count_d   = '0;
                cand_d    = W'(2);
                div_d     = W'(2);
                state_d   = (numMax < W'(2)) ? DONE : TEST;
            end

            TEST: begin
                if (limit_changed) begin
                    state_d = START;
                end else if (is_prime || is_composite) begin
                    checked_d = cand_q;
                    if (is_prime) begin
                        prime_d = cand_q;
                        count_d = count_q + W'(1);
                    end
                    if (cand_q == max_q) begin
                        state_d = DONE;
                    end else begin
                        cand_d = cand_q + W'(1);
                        div_d  = W'(2);
                    end
                end else begin
                    div_d = div_q + W'(1);
                end
            end

            DONE: begin
                if (limit_changed) begin
                    state_d = START;
                end
            end

            default: begin
                state_d = START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= START;
            max_q     <= '0;
            cand_q    <= W'(2);
            div_q     <= W'(2);
            prime_q   <= '0;
            checked_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            cand_q    <= cand_d;
            div_q     <= div_d;
            prime_q   <= prime_d;
            checked_q <= checked_d;
            count_q   <= count_d;
        end
    end

    assign prime          = prime_q;
    assign numberChecked  = checked_q;
    assign numberOfPrimes = count_q;

endmodule

// File: tb/tb_prime_number.sv
// Directed testbench for prime_number: reset, full scans, limit changes and async reset.
module tb_prime_number;

    localparam int W = 11;

    logic         clk;
    logic         rst;
    logic [W-1:0] numMax;
    logic [W-1:0] prime;
    logic [W-1:0] numberChecked;
    logic [W-1:0] numberOfPrimes;

    int tests_run;
    int tests_failed;

    prime_number #(.W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .numMax         (numMax),
        .prime          (prime),
        .numberChecked  (numberChecked),
        .numberOfPrimes (numberOfPrimes)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges, then park on the falling edge for sampling/driving.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_checked(input logic [W-1:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (numberChecked == target) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] sweep [4];
        sweep = '{W'(0), W'(10), W'(2047), W'(5)};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            numMax = sweep[i];
            step(3);
            tests_run++;
            if ({prime, numberChecked, numberOfPrimes} !== {3*W{1'b0}}) begin
                tests_failed++;
                $display("[TB] FAIL reset_held[%0d]: got %0d/%0d/%0d expected 0/0/0",
                         i, prime, numberChecked, numberOfPrimes);
            end
        end
    endtask

    task automatic test_basic_scan();
        numMax = W'(10);
        rst    = 1'b1;
        step(1);
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {3*W{1'b0}}) begin
            tests_failed++;
            $display("[TB] FAIL basic_start: got %0d/%0d/%0d expected 0/0/0",
                     prime, numberChecked, numberOfPrimes);
        end
        step(1);
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {W'(2), W'(2), W'(1)}) begin
            tests_failed++;
            $display("[TB] FAIL basic_edge2: got %0d/%0d/%0d expected 2/2/1",
                     prime, numberChecked, numberOfPrimes);
        end
        step(11);
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {W'(7), W'(10), W'(4)}) begin
            tests_failed++;
            $display("[TB] FAIL basic_edge13: got %0d/%0d/%0d expected 7/10/4",
                     prime, numberChecked, numberOfPrimes);
        end
        step(5);
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {W'(7), W'(10), W'(4)}) begin
            tests_failed++;
            $display("[TB] FAIL basic_hold: got %0d/%0d/%0d expected 7/10/4",
                     prime, numberChecked, numberOfPrimes);
        end
    endtask

    task automatic test_limit_change();
        bit ok;
        numMax = W'(20);
        step(1);
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {W'(7), W'(10), W'(4)}) begin
            tests_failed++;
            $display("[TB] FAIL change_first_edge: got %0d/%0d/%0d expected 7/10/4",
                     prime, numberChecked, numberOfPrimes);
        end
        step(1);
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {3*W{1'b0}}) begin
            tests_failed++;
            $display("[TB] FAIL change_cleared: got %0d/%0d/%0d expected 0/0/0",
                     prime, numberChecked, numberOfPrimes);
        end
        wait_checked(W'(20), 200, ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL change_timeout: got checked=%0d expected 20", numberChecked);
        end
        step(3);
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {W'(19), W'(20), W'(8)}) begin
            tests_failed++;
            $display("[TB] FAIL change_result: got %0d/%0d/%0d expected 19/20/8",
                     prime, numberChecked, numberOfPrimes);
        end
    endtask

    task automatic test_mid_scan_change();
        bit ok;
        numMax = W'(1000);
        step(25);
        numMax = W'(20);
        step(2);
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {3*W{1'b0}}) begin
            tests_failed++;
            $display("[TB] FAIL midscan_cleared: got %0d/%0d/%0d expected 0/0/0",
                     prime, numberChecked, numberOfPrimes);
        end
        wait_checked(W'(20), 200, ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midscan_timeout: got checked=%0d expected 20", numberChecked);
        end
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {W'(19), W'(20), W'(8)}) begin
            tests_failed++;
            $display("[TB] FAIL midscan_result: got %0d/%0d/%0d expected 19/20/8",
                     prime, numberChecked, numberOfPrimes);
        end
    endtask

    task automatic test_small_limits();
        numMax = W'(0);
        step(2);
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {3*W{1'b0}}) begin
            tests_failed++;
            $display("[TB] FAIL limit0: got %0d/%0d/%0d expected 0/0/0",
                     prime, numberChecked, numberOfPrimes);
        end
        numMax = W'(1);
        step(2);
        step(4);
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {3*W{1'b0}}) begin
            tests_failed++;
            $display("[TB] FAIL limit1_hold: got %0d/%0d/%0d expected 0/0/0",
                     prime, numberChecked, numberOfPrimes);
        end
        rst    = 1'b0;
        numMax = W'(2);
        @(negedge clk);
        rst = 1'b1;
        step(2);
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {W'(2), W'(2), W'(1)}) begin
            tests_failed++;
            $display("[TB] FAIL limit2: got %0d/%0d/%0d expected 2/2/1",
                     prime, numberChecked, numberOfPrimes);
        end
        step(4);
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {W'(2), W'(2), W'(1)}) begin
            tests_failed++;
            $display("[TB] FAIL limit2_hold: got %0d/%0d/%0d expected 2/2/1",
                     prime, numberChecked, numberOfPrimes);
        end
    endtask

    task automatic test_large();
        bit ok;
        numMax = W'(1000);
        step(2);
        wait_checked(W'(1000), 20000, ok);
        tests_run++;
        if (ok !== 1'b1 ||
            {prime, numberChecked, numberOfPrimes} !== {W'(997), W'(1000), W'(168)}) begin
            tests_failed++;
            $display("[TB] FAIL scan1000: got %0d/%0d/%0d expected 997/1000/168",
                     prime, numberChecked, numberOfPrimes);
        end
        numMax = W'(2047);
        step(2);
        wait_checked(W'(2047), 40000, ok);
        tests_run++;
        if (ok !== 1'b1 ||
            {prime, numberChecked, numberOfPrimes} !== {W'(2039), W'(2047), W'(309)}) begin
            tests_failed++;
            $display("[TB] FAIL scan2047: got %0d/%0d/%0d expected 2039/2047/309",
                     prime, numberChecked, numberOfPrimes);
        end
    endtask

    task automatic test_async_reset();
        numMax = W'(1000);
        step(30);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {3*W{1'b0}}) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got %0d/%0d/%0d expected 0/0/0",
                     prime, numberChecked, numberOfPrimes);
        end
        @(negedge clk);
        numMax = W'(10);
        step(1);
        rst = 1'b1;
        step(13);
        tests_run++;
        if ({prime, numberChecked, numberOfPrimes} !== {W'(7), W'(10), W'(4)}) begin
            tests_failed++;
            $display("[TB] FAIL async_rescan: got %0d/%0d/%0d expected 7/10/4",
                     prime, numberChecked, numberOfPrimes);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        numMax       = '0;

        test_reset();
        test_basic_scan();
        test_limit_change();
        test_mid_scan_change();
        test_small_limits();
        test_large();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/prime_number.md
Name: prime_number

Overview:
- Sequential prime scanner. It tests every integer from 2 up to the programmed limit numMax by trial division, one trial divisor per clock.
- It exposes three values: the most recent prime found, the last candidate fully evaluated, and the running prime count.
- Standalone compute block with one clock domain and no handshake. It stops at numMax and holds its results.

Parameters:
- W, 11, width of numMax and of all outputs; candidates span 0..2^W-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately; release synchronously handled by next clk edge).
- numMax  input  W  inclusive upper limit of the scan; sampled every clock.
- prime  output  W  most recently found prime; 0 if none yet.
- numberChecked  output  W  last candidate whose primality decision is complete; 0 if none yet.
- numberOfPrimes  output  W  count of primes found in 2..numberChecked.

Behaviour:
- Internal registers: maxReg (latched limit), cand (current candidate), div (current trial divisor), and state.
- States are START, TEST, DONE.
- Reset (rst=0, asynchronous): prime=0, numberChecked=0, numberOfPrimes=0, cand=2, div=2, maxReg=0, state=START. Held while rst=0.
- START (one cycle):
  - maxReg<=numMax; prime/numberChecked/numberOfPrimes<=0; cand<=2; div<=2.
  - If numMax<2, go to DONE. Otherwise go to TEST.
- TEST: exactly one divisor evaluated per clock. Priority order:
  - If div*div > cand (22-bit product, no truncation): cand is prime. prime<=cand, numberOfPrimes<=numberOfPrimes+1, numberChecked<=cand. Then advance.
  - Else if cand mod div == 0: cand is composite. numberChecked<=cand. Then advance.
  - Else: div<=div+1 and stay in TEST.
- Advance (same cycle as the decision):
  - If cand==maxReg, go to DONE.
  - Else cand<=cand+1, div<=2, stay in TEST.
- Cycle cost per candidate equals the number of divisors tried. Examples: 2, 3, 4 take 1 cycle each; 5, 7 and 9 take 2 cycles each.
- DONE: all outputs hold their values indefinitely.
- Limit change: in TEST or DONE, if numMax != maxReg at a clock edge, the next state is START. That cycle does no other TEST work. Outputs are cleared in START on the following edge.
- Width and boundaries:
  - cand never exceeds maxReg, so cand+1 never wraps.
  - The maximum numMax of 2047 gives prime=2039 and count=309, which fits in W bits.
  - div never exceeds 46 before the square test terminates.
- Reset mid-scan: asynchronous clear to the reset values above. The scan restarts from START after release.
- Outputs are registered, with no combinational path from numMax to the outputs.

Test Plan:
- Reset held (rst=0), numMax swept -> all outputs stay 0 regardless of numMax or clocks.
- Release rst with numMax=10 held -> after 13 rising edges (START + 12 TEST): prime=7, numberOfPrimes=4, numberChecked=10. After the 2nd edge: prime=2, count=1, checked=2. Values then hold.
- numMax=0 and numMax=1 -> DONE after the START edge; all outputs 0 and held.
- numMax=2 -> after 2 edges: prime=2, count=1, checked=2, held. numMax=1000 -> final prime=997, count=168, checked=1000. numMax=2047 -> final prime=2039, count=309, checked=2047.
- Change numMax from 10 to 20 in DONE -> START, outputs clear, rescan. Final prime=19, count=8, checked=20. Change numMax mid-scan -> restart from 2, with no stale count carried over.
- Assert rst asynchronously mid-scan (between edges) -> outputs 0 immediately. After release with numMax=10, results again match the 13-edge scenario.
